jpeg_stream_sched: RTL and testbench

//  Job sequencer in front of jpeg_decode. Accepts frame jobs (word base address + word length) and fetches
//  the 32-bit JPEG words from a 1-cycle-latency RAM. Buffers them in a small prefetch FIFO and feeds the

---
 rtl/jpeg_sched_pkg.sv | 15 +
 rtl/jpeg_stream_sched_if.sv | 47 ++++
 rtl/jpeg_word_fifo.sv | 61 ++++++
 rtl/jpeg_stream_sched.sv | 169 ++++++++++++++++
 tb/tb_jpeg_stream_sched.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/jpeg_sched_pkg.sv
// Shared types and constants for the JPEG stream scheduler.
// Holds the sequencer state encoding and the decoder word width.
package jpeg_sched_pkg;

    localparam int unsigned DATA_W      = 32;
    localparam int unsigned DEF_TIMEOUT = 65535;

    typedef enum logic [1:0] {
        StIdle,
        StStream,
        StFlush,
        StDone
    } sched_state_e;

endpackage

// File: rtl/jpeg_stream_sched_if.sv
// Bundle of job command, RAM read, decoder feed and status signals for jpeg_stream_sched.
// The slave modport is the scheduler; the master modport is its environment.
interface jpeg_stream_sched_if #(
    parameter int unsigned ADDR_W = 16
);
    import jpeg_sched_pkg::*;

    logic              cmd_valid;
    logic              cmd_ready;
    logic [ADDR_W-1:0] cmd_base;
    logic [ADDR_W-1:0] cmd_words;

    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rd_data;

    logic [DATA_W-1:0] dec_data;
    logic              dec_data_en;
    logic              dec_data_read;
    logic              dec_idle;
    logic              dec_out_en;
    logic [15:0]       dec_width;
    logic [15:0]       dec_height;

    logic              done;
    logic              busy;
    logic              err_timeout;
    logic              err_pixels;
    logic [15:0]       frame_cnt;
    logic [31:0]       pix_cnt;
    logic [31:0]       cycle_cnt;

    modport master (
        output cmd_valid, cmd_base, cmd_words, mem_rd_data,
        output dec_data_read, dec_idle, dec_out_en, dec_width, dec_height,
        input  cmd_ready, mem_rd_en, mem_addr, dec_data, dec_data_en,
        input  done, busy, err_timeout, err_pixels, frame_cnt, pix_cnt, cycle_cnt
    );

    modport slave (
        input  cmd_valid, cmd_base, cmd_words, mem_rd_data,
        input  dec_data_read, dec_idle, dec_out_en, dec_width, dec_height,
        output cmd_ready, mem_rd_en, mem_addr, dec_data, dec_data_en,
        output done, busy, err_timeout, err_pixels, frame_cnt, pix_cnt, cycle_cnt
    );

endinterface

// File: rtl/jpeg_word_fifo.sv
// Small synchronous prefetch FIFO with push, pop and a synchronous clear.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module jpeg_word_fifo #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned FIFO_AW = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_clear,
    input  logic               i_push,
    input  logic [DATA_W-1:0]  i_wdata,
    input  logic               i_pop,
    output logic [DATA_W-1:0]  o_rdata,
    output logic [FIFO_AW:0]   o_count,
    output logic               o_empty,
    output logic               o_full
);

    localparam int unsigned DEPTH = 2 ** FIFO_AW;

    logic [DATA_W-1:0]  r_mem [DEPTH];
    logic [FIFO_AW-1:0] r_wptr;
    logic [FIFO_AW-1:0] r_rptr;
    logic [FIFO_AW:0]   r_count;
    logic               w_do_push;
    logic               w_do_pop;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == (FIFO_AW + 1)'(DEPTH));
    assign o_count   = r_count;
    assign o_rdata   = r_mem[r_rptr];
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_do_push && w_do_pop) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wptr] <= i_wdata;
        end
    end

endmodule

// File: rtl/jpeg_stream_sched.sv
// Frame job sequencer: fetches JPEG words from RAM into a prefetch FIFO, feeds the decoder,
// detects end of frame and reports per-frame pixel/cycle counts and error flags.
module jpeg_stream_sched
    import jpeg_sched_pkg::*;
#(
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned FIFO_AW = 2,
    parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
    input logic                clk,
    input logic                rst,
    jpeg_stream_sched_if.slave bus
);

    localparam int unsigned DEPTH = 2 ** FIFO_AW;

    sched_state_e      r_state;
    sched_state_e      w_state_nxt;
    logic [ADDR_W-1:0] r_base;
    logic [ADDR_W-1:0] r_words;
    logic [ADDR_W-1:0] r_fetched;
    logic              r_inflight;
    logic              r_seen_busy;
    logic [31:0]       r_stall;
    logic [31:0]       r_pix_cnt;
    logic [31:0]       r_cycle_cnt;
    logic [15:0]       r_frame_cnt;
    logic              r_err_timeout;
    logic              r_err_pixels;

    logic              w_accept;
    logic              w_streaming;
    logic              w_rd_en;
    logic              w_push;
    logic              w_pop;
    logic              w_data_en;
    logic              w_end_frame;
    logic              w_empty_job;
    logic              w_abort;
    logic [31:0]       w_area;
    logic [DATA_W-1:0] w_fifo_rdata;
    logic [FIFO_AW:0]  w_fifo_count;
    logic              w_fifo_empty;
    logic              w_fifo_full;

    assign w_accept    = bus.cmd_valid && (r_state == StIdle);
    assign w_streaming = (r_state == StStream);
    assign w_area      = 32'(bus.dec_width) * 32'(bus.dec_height);

    // Reads already in flight count against FIFO space so a returning word always fits.
    assign w_rd_en = w_streaming && (r_fetched < r_words) && !w_fifo_full
                     && ((32'(w_fifo_count) + 32'(r_inflight)) < DEPTH);
    assign w_push    = r_inflight && w_streaming;
    assign w_data_en = w_streaming && !w_fifo_empty;
    assign w_pop     = w_data_en && bus.dec_data_read;

    assign w_empty_job = (r_words == '0);
    assign w_end_frame = r_seen_busy && bus.dec_idle;
    assign w_abort     = w_streaming && !w_empty_job && !w_end_frame && (r_stall >= TIMEOUT);

    jpeg_word_fifo #(
        .DATA_W  (DATA_W),
        .FIFO_AW (FIFO_AW)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_clear (r_state == StFlush),
        .i_push  (w_push),
        .i_wdata (bus.mem_rd_data),
        .i_pop   (w_pop),
        .o_rdata (w_fifo_rdata),
        .o_count (w_fifo_count),
        .o_empty (w_fifo_empty),
        .o_full  (w_fifo_full)
    );

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            StIdle: begin
                if (w_accept) begin
                    w_state_nxt = StStream;
                end
            end
            StStream: begin
                if (w_empty_job || w_end_frame || w_abort) begin
                    w_state_nxt = StFlush;
                end
            end
            StFlush: w_state_nxt = StDone;
            StDone:  w_state_nxt = StIdle;
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= StIdle;
            r_base        <= '0;
            r_words       <= '0;
            r_fetched     <= '0;
            r_inflight    <= 1'b0;
            r_seen_busy   <= 1'b0;
            r_stall       <= '0;
            r_pix_cnt     <= '0;
            r_cycle_cnt   <= '0;
            r_frame_cnt   <= '0;
            r_err_timeout <= 1'b0;
            r_err_pixels  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_inflight <= w_rd_en;
            if (w_rd_en) begin
                r_fetched <= r_fetched + 1'b1;
            end
            if (w_accept) begin
                r_base        <= bus.cmd_base;
                r_words       <= bus.cmd_words;
                r_fetched     <= '0;
                r_seen_busy   <= 1'b0;
                r_stall       <= '0;
                r_pix_cnt     <= '0;
                r_cycle_cnt   <= '0;
                r_err_timeout <= 1'b0;
                r_err_pixels  <= 1'b0;
            end
            if (w_streaming) begin
                if (!bus.dec_idle) begin
                    r_seen_busy <= 1'b1;
                end
                if (w_pop || bus.dec_out_en) begin
                    r_stall <= '0;
                end else if (r_stall != '1) begin
                    r_stall <= r_stall + 1'b1;
                end
                if (bus.dec_out_en) begin
                    r_pix_cnt <= r_pix_cnt + 1'b1;
                end
                if (w_abort) begin
                    r_err_timeout <= 1'b1;
                end
            end
            if (r_state != StIdle) begin
                r_cycle_cnt <= r_cycle_cnt + 1'b1;
            end
            // A timed-out frame has no meaningful pixel total, so only the timeout is reported.
            if (r_state == StFlush) begin
                r_err_pixels <= !r_err_timeout && (r_pix_cnt != w_area);
            end
            if (r_state == StDone) begin
                r_frame_cnt <= r_frame_cnt + 1'b1;
            end
        end
    end

    assign bus.cmd_ready   = (r_state == StIdle);
    assign bus.busy        = (r_state != StIdle);
    assign bus.done        = (r_state == StDone);
    assign bus.mem_rd_en   = w_rd_en;
    assign bus.mem_addr    = r_base + r_fetched;
    assign bus.dec_data    = w_fifo_empty ? '0 : w_fifo_rdata;
    assign bus.dec_data_en = w_data_en;
    assign bus.err_timeout = r_err_timeout;
    assign bus.err_pixels  = r_err_pixels;
    assign bus.frame_cnt   = r_frame_cnt;
    assign bus.pix_cnt     = r_pix_cnt;
    assign bus.cycle_cnt   = r_cycle_cnt;

endmodule

// File: tb/tb_jpeg_stream_sched.sv
// Directed bench for jpeg_stream_sched with a RAM model, a decoder model and a word scoreboard.
module tb_jpeg_stream_sched;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    jpeg_stream_sched_if #(.ADDR_W(16)) bus ();

    jpeg_stream_sched #(
        .ADDR_W  (16),
        .FIFO_AW (2),
        .TIMEOUT (100)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // Job description, written only by the main sequence.
    int          job_gen    = 0;
    bit          job_on     = 1'b0;
    logic [15:0] cur_base   = '0;
    logic [15:0] cur_words  = '0;
    int          rd_period  = 0;
    int          pix_target = 0;

    // Observations, written only by the decoder/monitor process.
    int          gen_seen  = 0;
    int          cyc       = 0;
    int          consumed  = 0;
    int          pix_sent  = 0;
    int          n_rd      = 0;
    int          n_pop     = 0;
    int          max_out   = 0;
    int          done_cnt  = 0;
    int          bad_data  = 0;
    logic [15:0] addr_q [$];

    function automatic logic [31:0] ram_word(input logic [15:0] a);
        return {~a, a} ^ 32'h5A5A_0000;
    endfunction

    function automatic bit addr_match(input logic [15:0] base, input int n);
        logic [15:0] e;
        if (addr_q.size() != n) return 1'b0;
        for (int i = 0; i < n; i++) begin
            e = base + 16'(i);
            if (addr_q[i] !== e) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // 1-cycle-latency RAM: data appears just after the edge that follows the read strobe.
    initial begin
        logic        pend;
        logic [15:0] a;
        forever begin
            @(negedge clk);
            pend = bus.mem_rd_en;
            a    = bus.mem_addr;
            @(posedge clk);
            #1;
            if (pend) bus.mem_rd_data = ram_word(a);
        end
    end

    // Decoder model and monitor; all DUT sampling and decoder driving happens on negedge.
    initial begin
        forever begin
            @(negedge clk);
            if (gen_seen != job_gen) begin
                gen_seen = job_gen;
                consumed = 0;
                pix_sent = 0;
                n_rd     = 0;
                n_pop    = 0;
                max_out  = 0;
                done_cnt = 0;
                bad_data = 0;
                addr_q.delete();
            end
            cyc++;
            if (bus.done === 1'b1) done_cnt++;
            if (bus.mem_rd_en === 1'b1) begin
                addr_q.push_back(bus.mem_addr);
                n_rd++;
            end
            if (n_rd - n_pop > max_out) max_out = n_rd - n_pop;
            bus.dec_idle = !(job_on && (consumed < int'(cur_words) || pix_sent < pix_target));
            if (job_on && consumed == int'(cur_words) && pix_sent < pix_target) begin
                bus.dec_out_en = 1'b1;
                pix_sent++;
            end else begin
                bus.dec_out_en = 1'b0;
            end
            bus.dec_data_read = (rd_period != 0) && (cyc % rd_period == 0);
            if (bus.dec_data_en === 1'b1 && bus.dec_data_read) begin
                if (bus.dec_data !== ram_word(cur_base + 16'(consumed))) bad_data++;
                consumed++;
                n_pop++;
            end
        end
    end

    task automatic start_job(input logic [15:0] base, input logic [15:0] words,
                             input int rp, input int pixt);
        job_gen++;
        cur_base      = base;
        cur_words     = words;
        rd_period     = rp;
        pix_target    = pixt;
        bus.cmd_base  = base;
        bus.cmd_words = words;
        bus.cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        job_on        = 1'b1;
    endtask

    task automatic wait_done(input int limit, output int n, output bit got);
        n   = 0;
        got = 1'b0;
        while (n < limit && !got) begin
            @(posedge clk);
            #1;
            n++;
            if (bus.done === 1'b1) got = 1'b1;
        end
        if (got) begin
            @(posedge clk);
            #1;
        end
        job_on = 1'b0;
    endtask

    initial begin
        int n;
        bit got;
        bus.cmd_valid  = 1'b0;
        bus.cmd_base   = '0;
        bus.cmd_words  = '0;
        bus.dec_width  = '0;
        bus.dec_height = '0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", 32'(bus.cmd_ready), 32'd1);
        check("rst_flags", 32'({bus.busy, bus.done, bus.mem_rd_en, bus.dec_data_en,
                                bus.err_timeout, bus.err_pixels}), 32'd0);
        check("rst_counts", bus.pix_cnt | bus.cycle_cnt | 32'(bus.frame_cnt), 32'd0);
        check("rst_data", bus.dec_data, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // 1) short frame, decoder reads every cycle
        start_job(16'h0010, 16'd4, 1, 0);
        wait_done(300, n, got);
        check("t1_done", 32'(got), 32'd1);
        check("t1_addrs", 32'(addr_match(16'h0010, 4)), 32'd1);
        check("t1_words", 32'(consumed), 32'd4);
        check("t1_data", 32'(bad_data), 32'd0);
        check("t1_done_cnt", 32'(done_cnt), 32'd1);
        check("t1_frame", 32'(bus.frame_cnt), 32'd1);
        check("t1_err", 32'({bus.err_timeout, bus.err_pixels}), 32'd0);

        // 2) slow decoder: FIFO back-pressure, no loss or duplication
        start_job(16'h0200, 16'd16, 5, 0);
        wait_done(500, n, got);
        check("t2_done", 32'(got), 32'd1);
        check("t2_addrs", 32'(addr_match(16'h0200, 16)), 32'd1);
        check("t2_max_occ", 32'(max_out), 32'd4);
        check("t2_words", 32'(consumed), 32'd16);
        check("t2_data", 32'(bad_data), 32'd0);
        check("t2_frame", 32'(bus.frame_cnt), 32'd2);

        // 3) pixel accounting against width*height
        bus.dec_width  = 16'd8;
        bus.dec_height = 16'd8;
        start_job(16'h0300, 16'd4, 1, 64);
        wait_done(500, n, got);
        check("t3a_pix", bus.pix_cnt, 32'd64);
        check("t3a_err", 32'({bus.err_timeout, bus.err_pixels}), 32'd0);
        check("t3a_frame", 32'(bus.frame_cnt), 32'd3);
        start_job(16'h0300, 16'd4, 1, 63);
        wait_done(500, n, got);
        check("t3b_pix", bus.pix_cnt, 32'd63);
        check("t3b_err", 32'({bus.err_timeout, bus.err_pixels}), 32'd1);
        check("t3b_frame", 32'(bus.frame_cnt), 32'd4);

        // 4) decoder never reads: stall timeout aborts the job
        start_job(16'h0400, 16'd8, 0, 0);
        wait_done(500, n, got);
        check("t4_latency", 32'(n), 32'd102);
        check("t4_err", 32'({bus.err_timeout, bus.err_pixels}), 32'd2);
        check("t4_reads", 32'(n_rd), 32'd4);
        check("t4_cycles", bus.cycle_cnt, 32'd103);
        check("t4_fifo_empty", 32'(bus.dec_data_en), 32'd0);
        check("t4_frame", 32'(bus.frame_cnt), 32'd5);

        // 5) empty job, then address wrap
        bus.dec_width  = 16'd0;
        bus.dec_height = 16'd0;
        start_job(16'h0020, 16'd0, 1, 0);
        wait_done(50, n, got);
        check("t5a_latency", 32'(n), 32'd2);
        check("t5a_reads", 32'(n_rd), 32'd0);
        check("t5a_cycles", bus.cycle_cnt, 32'd3);
        check("t5a_frame", 32'(bus.frame_cnt), 32'd6);
        start_job(16'hFFFE, 16'd4, 1, 0);
        wait_done(300, n, got);
        check("t5b_addrs", 32'(addr_match(16'hFFFE, 4)), 32'd1);
        check("t5b_data", 32'(bad_data), 32'd0);
        check("t5b_frame", 32'(bus.frame_cnt), 32'd7);

        // 6) reset in the middle of a stream, then a clean job
        start_job(16'h0100, 16'd16, 5, 0);
        repeat (10) @(posedge clk);
        #1;
        check("t6_busy_before", 32'(bus.busy), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("t6_rst_ready", 32'(bus.cmd_ready), 32'd1);
        check("t6_rst_flags", 32'({bus.busy, bus.mem_rd_en, bus.done}), 32'd0);
        check("t6_rst_frame", 32'(bus.frame_cnt), 32'd0);
        rst    = 1'b0;
        job_on = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("t6_no_done", 32'(done_cnt), 32'd0);
        start_job(16'h0040, 16'd4, 1, 0);
        wait_done(300, n, got);
        check("t6_addrs", 32'(addr_match(16'h0040, 4)), 32'd1);
        check("t6_data", 32'(bad_data), 32'd0);
        check("t6_done_cnt", 32'(done_cnt), 32'd1);
        check("t6_frame", 32'(bus.frame_cnt), 32'd1);
        check("t6_err", 32'({bus.err_timeout, bus.err_pixels}), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
